// File: rtl/target_pkg.sv
// ============================================================================
// Module      : target_pkg
// Description : Shared widths, FSM encoding and the slot-index folding helper
//               used by the target spawner and its slot sub-blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package target_pkg;

    localparam int c_idx_w   = 4;   // slot index width
    localparam int c_score_w = 32;  // score width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    // The generator produces 0..15; values 10..15 fold back onto slots 0..5.
    function automatic logic [c_idx_w-1:0] fold_idx(input logic [c_idx_w-1:0] idx);
        return (idx >= 4'd10) ? (idx - 4'd10) : idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/target_spawner_if.sv
// ============================================================================
// Module      : target_spawner_if
// Description : Control/status bundle between the game logic and the target
//               spawner. slave = spawner side, master = game/driver side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface target_spawner_if
    import target_pkg::*;
#(
    parameter int NUM_TARGETS = 10
);
    logic                   game_en;
    logic [c_idx_w-1:0]     ran_num_ten;
    logic                   hit_valid;
    logic [c_idx_w-1:0]     hit_idx;
    logic [NUM_TARGETS-1:0] target_active;
    logic [c_score_w-1:0]   score;
    logic                   spawn_pulse;
    logic                   hit_ok;
    logic                   hit_bad;
    logic                   miss_pulse;
    logic                   game_over;

    modport slave (
        input  game_en, ran_num_ten, hit_valid, hit_idx,
        output target_active, score, spawn_pulse, hit_ok, hit_bad, miss_pulse, game_over
    );

    modport master (
        output game_en, ran_num_ten, hit_valid, hit_idx,
        input  target_active, score, spawn_pulse, hit_ok, hit_bad, miss_pulse, game_over
    );
endinterface

`default_nettype wire

// File: rtl/target_slot.sv
// ============================================================================
// Module      : target_slot
// Description : One on-screen slot: a live bit plus its lifetime down-counter.
//               expire_o flags the cycle the counter sits at zero; a hit in
//               that same cycle takes priority and suppresses the expiry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module target_slot #(
    parameter int LIFETIME = 50000000
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic spawn_i,
    input  wire logic hit_i,
    input  wire logic flush_i,
    output logic      live_o,
    output logic      expire_o
);

    localparam int                c_cnt_w = (LIFETIME > 1) ? $clog2(LIFETIME) : 1;
    localparam logic [c_cnt_w-1:0] c_load = c_cnt_w'(LIFETIME - 1);

    logic               live_q;
    logic [c_cnt_w-1:0] cnt_q;

    // Occupancy and lifetime: flush beats spawn beats hit beats ageing.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            live_q <= 1'b0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            live_q <= 1'b0;
        end else if (spawn_i) begin
            live_q <= 1'b1;
            cnt_q  <= c_load;
        end else if (hit_i) begin
            live_q <= 1'b0;
        end else if (live_q) begin
            if (cnt_q == '0) begin
                live_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign live_o   = live_q;
    assign expire_o = live_q && (cnt_q == '0) && !hit_i;

endmodule

`default_nettype wire

// File: rtl/target_spawner.sv
// ============================================================================
// Module      : target_spawner
// Description : Game FSM, spawn timer, free-slot probe, score and miss count
//               for NUM_TARGETS target slots. Score never drops below
//               SCORE_INIT (>=1) because it feeds a modulus downstream.
//               Optional macro MISS_PENALTY_EN: each expiry costs one point,
//               floored at SCORE_INIT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module target_spawner
    import target_pkg::*;
#(
    parameter int SPAWN_PERIOD = 25000000,
    parameter int LIFETIME     = 50000000,
    parameter int NUM_TARGETS  = 10,
    parameter int SCORE_INIT   = 1,
    parameter int HIT_POINTS   = 1,
    parameter int MAX_MISSES   = 5
) (
    input  wire logic         clock,
    input  wire logic         reset,
    target_spawner_if.slave   bus
);

    localparam int c_tmr_w  = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam int c_miss_w = $clog2(MAX_MISSES + 1);
    localparam int c_nexp_w = $clog2(NUM_TARGETS + 1);
    localparam int c_sum_w  = c_miss_w + c_nexp_w + 1;
    localparam int c_pos_w  = c_idx_w + 1;
    localparam logic [c_score_w-1:0] c_score_init = c_score_w'(SCORE_INIT);

    state_t                 state_q, state_d;
    logic [c_tmr_w-1:0]     timer_q, timer_d;
    logic [c_miss_w-1:0]    miss_q, miss_d;
    logic [c_score_w-1:0]   score_q, score_d;
    logic                   spawn_pulse_q, hit_ok_q, hit_bad_q, miss_pulse_q;

    logic [NUM_TARGETS-1:0] live, expire, exp_eff, hit_vec, spawn_vec;
    logic                   run, enter_run, flush, tick, hit_any, hit_bad_d;
    logic [c_nexp_w-1:0]    n_exp;
    logic [c_sum_w-1:0]     miss_sum;

    assign run       = (state_q == ST_RUN);
    assign enter_run = (state_q == ST_IDLE) && bus.game_en;
    assign tick      = run && (timer_q == c_tmr_w'(SPAWN_PERIOD - 1));
    assign flush     = run && (state_d != ST_RUN);

    // Hits are judged against registered occupancy only.
    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            hit_vec[i] = run && bus.hit_valid && (bus.hit_idx == c_idx_w'(i)) && live[i];
        end
        hit_any   = |hit_vec;
        hit_bad_d = run && bus.hit_valid && !hit_any;
    end

    // Count this cycle's expiries and fold them into the saturating miss count.
    always_comb begin
        exp_eff = run ? expire : '0;
        n_exp   = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            n_exp = n_exp + c_nexp_w'(exp_eff[i]);
        end
        miss_sum = c_sum_w'(miss_q) + c_sum_w'(n_exp);
        miss_d   = miss_q;
        if (enter_run) begin
            miss_d = '0;
        end else if (run) begin
            if (miss_sum >= c_sum_w'(MAX_MISSES)) begin
                miss_d = c_miss_w'(MAX_MISSES);
            end else begin
                miss_d = c_miss_w'(miss_sum);
            end
        end
    end

    // Game FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.game_en) state_d = ST_RUN;
            ST_RUN: begin
                if (!bus.game_en) begin
                    state_d = ST_IDLE;
                end else if (miss_d >= c_miss_w'(MAX_MISSES)) begin
                    state_d = ST_OVER;
                end
            end
            ST_OVER: if (!bus.game_en) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Free-slot probe: first free slot at or above the folded index, wrapping.
    always_comb begin
        logic                 found;
        logic [c_idx_w-1:0]   base;
        logic [c_pos_w-1:0]   pos;
        spawn_vec = '0;
        found     = 1'b0;
        base      = fold_idx(bus.ran_num_ten);
        pos       = '0;
        for (int k = 0; k < NUM_TARGETS; k++) begin
            pos = {1'b0, base} + c_pos_w'(k);
            if (pos >= c_pos_w'(NUM_TARGETS)) begin
                pos = pos - c_pos_w'(NUM_TARGETS);
            end
            if (!found && !live[pos[c_idx_w-1:0]]) begin
                found                      = 1'b1;
                spawn_vec[pos[c_idx_w-1:0]] = 1'b1;
            end
        end
        if (!(tick && (state_d == ST_RUN))) begin
            spawn_vec = '0;
        end
    end

    // Spawn timer and score next-state.
    always_comb begin
        logic [c_score_w:0] add;
        timer_d = '0;
        if (run && !tick) begin
            timer_d = timer_q + 1'b1;
        end

        score_d = score_q;
        add     = '0;
        if (enter_run) begin
            score_d = c_score_init;
        end else if (run) begin
            add     = {1'b0, score_q} + (hit_any ? (c_score_w + 1)'(HIT_POINTS) : '0);
            score_d = add[c_score_w] ? '1 : add[c_score_w-1:0];
`ifdef MISS_PENALTY_EN
            if ((score_d - c_score_init) < c_score_w'(n_exp)) begin
                score_d = c_score_init;
            end else begin
                score_d = score_d - c_score_w'(n_exp);
            end
`endif
        end
    end

    // State, counters, score and one-cycle status pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            miss_q        <= '0;
            score_q       <= c_score_init;
            spawn_pulse_q <= 1'b0;
            hit_ok_q      <= 1'b0;
            hit_bad_q     <= 1'b0;
            miss_pulse_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            miss_q        <= miss_d;
            score_q       <= score_d;
            spawn_pulse_q <= |spawn_vec;
            hit_ok_q      <= hit_any;
            hit_bad_q     <= hit_bad_d;
            miss_pulse_q  <= |exp_eff;
        end
    end

    for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_slot
        target_slot #(
            .LIFETIME (LIFETIME)
        ) u_slot (
            .clock    (clock),
            .reset    (reset),
            .spawn_i  (spawn_vec[g]),
            .hit_i    (hit_vec[g]),
            .flush_i  (flush),
            .live_o   (live[g]),
            .expire_o (expire[g])
        );
    end

    assign bus.target_active = live;
    assign bus.score         = score_q;
    assign bus.spawn_pulse   = spawn_pulse_q;
    assign bus.hit_ok        = hit_ok_q;
    assign bus.hit_bad       = hit_bad_q;
    assign bus.miss_pulse    = miss_pulse_q;
    assign bus.game_over     = (state_q == ST_OVER);

endmodule

`default_nettype wire

// File: tb/tb_target_spawner.sv
// ============================================================================
// Module      : tb_target_spawner
// Description : Directed bench for target_spawner. Instance A uses
//               SPAWN_PERIOD=8, LIFETIME=20, MAX_MISSES=3; instance B uses a
//               short period and long lifetime so all ten slots can fill.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_target_spawner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    target_spawner_if #(.NUM_TARGETS(10)) ifa ();
    target_spawner_if #(.NUM_TARGETS(10)) ifb ();

    target_spawner #(
        .SPAWN_PERIOD (8), .LIFETIME (20), .NUM_TARGETS (10),
        .SCORE_INIT (1), .HIT_POINTS (1), .MAX_MISSES (3)
    ) dut_a (.clock (clk), .reset (rst), .bus (ifa));

    target_spawner #(
        .SPAWN_PERIOD (2), .LIFETIME (200), .NUM_TARGETS (10),
        .SCORE_INIT (1), .HIT_POINTS (1), .MAX_MISSES (3)
    ) dut_b (.clock (clk), .reset (rst), .bus (ifb));

`ifdef MISS_PENALTY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_score;
    logic [9:0] exp_q[$];   // expected target_active after each spawn
    logic [9:0] acc;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare a spawn event on instance A against the head of the scoreboard.
    task automatic chk_spawn_a(input string tag);
        chk({tag, "_pulse"}, {31'd0, ifa.spawn_pulse}, 32'd1);
        chk({tag, "_sb"}, {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) chk({tag, "_active"}, {22'd0, ifa.target_active}, {22'd0, exp_q.pop_front()});
    endtask

    function automatic int dec_score(input int s);
        return (PEN != 0 && s > 1) ? s - 1 : s;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int seen;
        ifa.game_en = 0; ifa.ran_num_ten = '0; ifa.hit_valid = 0; ifa.hit_idx = '0;
        ifb.game_en = 0; ifb.ran_num_ten = '0; ifb.hit_valid = 0; ifb.hit_idx = '0;

        // ---- reset state ----
        tick(); tick();
        chk("rst_active", {22'd0, ifa.target_active}, 32'd0);
        chk("rst_score", ifa.score, 32'd1);
        chk("rst_pulses", {28'd0, ifa.spawn_pulse, ifa.hit_ok, ifa.hit_bad, ifa.miss_pulse}, 32'd0);
        chk("rst_over", {31'd0, ifa.game_over}, 32'd0);
        rst = 1'b0;
        tick();

        // ---- first spawn at slot 4 ----
        ifa.ran_num_ten = 4'd4;
        ifa.game_en     = 1'b1;
        exp_q.push_back(10'b0000010000);
        tick(); cyc = 0;                         // E0: RUN entered
        n = 0;
        while (!ifa.spawn_pulse && n < 20) begin tick(); n++; end
        chk("spawn1_cycle", cyc, 32'd8);
        chk_spawn_a("spawn1");
        exp_score = 1;
        chk("spawn1_score", ifa.score, exp_score);

        // ---- hit slot 4, then hit it again ----
        ifa.hit_valid = 1'b1; ifa.hit_idx = 4'd4;
        tick();                                  // E9
        exp_score = 2;
        chk("hit1_ok", {31'd0, ifa.hit_ok}, 32'd1);
        chk("hit1_active", {22'd0, ifa.target_active}, 32'd0);
        chk("hit1_score", ifa.score, exp_score);
        tick();                                  // E10
        ifa.hit_valid = 1'b0;
        chk("hit2_bad", {31'd0, ifa.hit_bad}, 32'd1);
        chk("hit2_ok", {31'd0, ifa.hit_ok}, 32'd0);
        chk("hit2_score", ifa.score, exp_score);

        // ---- slot 9, then wrap to slot 0, then folded 12 -> slot 2 ----
        ifa.ran_num_ten = 4'd9;
        exp_q.push_back(10'h200);
        exp_q.push_back(10'h201);
        run_to(16); chk_spawn_a("spawn9");
        run_to(24); chk_spawn_a("spawn_wrap0");
        ifa.ran_num_ten = 4'd12;
        exp_q.push_back(10'h205);
        run_to(32); chk_spawn_a("spawn_fold2");
        ifa.ran_num_ten = 4'd5;

        // ---- slot 9 expires exactly 20 cycles after its spawn ----
        run_to(35);
        chk("miss1_early", {31'd0, ifa.miss_pulse}, 32'd0);
        run_to(36);
        exp_score = dec_score(exp_score);
        chk("miss1_pulse", {31'd0, ifa.miss_pulse}, 32'd1);
        chk("miss1_active", {22'd0, ifa.target_active}, 32'h005);
        chk("miss1_score", ifa.score, exp_score);

        exp_q.push_back(10'h025);
        run_to(40); chk_spawn_a("spawn5");
        run_to(44);
        exp_score = dec_score(exp_score);
        chk("miss2_pulse", {31'd0, ifa.miss_pulse}, 32'd1);
        chk("miss2_score", ifa.score, exp_score);
        exp_q.push_back(10'h064);                // 5 busy -> 6
        run_to(48); chk_spawn_a("spawn_probe6");

        // ---- hit slot 2 on the cycle its counter is zero ----
        run_to(51);
        ifa.hit_valid = 1'b1; ifa.hit_idx = 4'd2;
        tick();                                  // E52
        ifa.hit_valid = 1'b0;
        exp_score = exp_score + 1;
        chk("hitexp_ok", {31'd0, ifa.hit_ok}, 32'd1);
        chk("hitexp_miss", {31'd0, ifa.miss_pulse}, 32'd0);
        chk("hitexp_score", ifa.score, exp_score);
        chk("hitexp_active", {22'd0, ifa.target_active}, 32'h060);

        exp_q.push_back(10'h0E0);                // 5,6 busy -> 7
        run_to(56); chk_spawn_a("spawn_probe7");

        // ---- third miss ends the game ----
        run_to(60);
        exp_score = dec_score(exp_score);
        chk("over_miss", {31'd0, ifa.miss_pulse}, 32'd1);
        chk("over_flag", {31'd0, ifa.game_over}, 32'd1);
        chk("over_active", {22'd0, ifa.target_active}, 32'd0);
        chk("over_score", ifa.score, exp_score);
        ifa.hit_valid = 1'b1; ifa.hit_idx = 4'd7;
        tick();
        ifa.hit_valid = 1'b0;
        chk("over_hit_ignored", {30'd0, ifa.hit_ok, ifa.hit_bad}, 32'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (ifa.spawn_pulse) seen++; end
        chk("over_no_spawn", seen, 32'd0);
        ifa.game_en = 1'b0;
        tick();
        chk("idle_over_clr", {31'd0, ifa.game_over}, 32'd0);
        chk("idle_score_held", ifa.score, exp_score);

        // ---- restart, three live targets, async reset mid-cycle ----
        ifa.ran_num_ten = 4'd0;
        ifa.game_en = 1'b1;
        tick(); cyc = 0;
        chk("restart_score", ifa.score, 32'd1);
        exp_q.push_back(10'h001);
        exp_q.push_back(10'h003);
        exp_q.push_back(10'h007);
        run_to(8);  chk_spawn_a("r_spawn0");
        run_to(16); chk_spawn_a("r_spawn1");
        run_to(24); chk_spawn_a("r_spawn2");
        #2 rst = 1'b1;
        #1;
        chk("arst_active", {22'd0, ifa.target_active}, 32'd0);
        chk("arst_score", ifa.score, 32'd1);
        chk("arst_pulse", {31'd0, ifa.spawn_pulse}, 32'd0);
        chk("arst_over", {31'd0, ifa.game_over}, 32'd0);
        ifa.game_en = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // ---- instance B: fill all ten slots, eleventh spawn dropped ----
        ifb.ran_num_ten = 4'd7;
        acc = '0;
        for (int k = 0; k < 10; k++) begin
            acc[(7 + k) % 10] = 1'b1;
            exp_q.push_back(acc);
        end
        ifb.game_en = 1'b1;
        tick(); cyc = 0;
        seen = 0;
        while (cyc < 20) begin
            tick();
            if (ifb.spawn_pulse) begin
                seen++;
                chk("fill_sb", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) chk("fill_active", {22'd0, ifb.target_active}, {22'd0, exp_q.pop_front()});
            end
        end
        chk("fill_count", seen, 32'd10);
        chk("fill_full", {22'd0, ifb.target_active}, 32'h3FF);
        run_to(22);
        chk("full_drop_pulse", {31'd0, ifb.spawn_pulse}, 32'd0);
        chk("full_drop_active", {22'd0, ifb.target_active}, 32'h3FF);
        ifb.hit_valid = 1'b1; ifb.hit_idx = 4'd12;
        tick();
        chk("b_range_bad", {30'd0, ifb.hit_ok, ifb.hit_bad}, 32'd1);
        ifb.hit_idx = 4'd3;
        tick();
        ifb.hit_valid = 1'b0;
        chk("b_hit3_ok", {30'd0, ifb.hit_ok, ifb.hit_bad}, 32'd2);
        chk("b_hit3_active", {22'd0, ifb.target_active}, 32'h3F7);
        chk("b_hit3_score", ifb.score, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/target_spawner.md
Name: target_spawner

Overview:
- Downstream consumer of the pseudo-random target index (0-9) produced by the random number generator.
- Periodically spawns a target into one of NUM_TARGETS on-screen slots and ages each live target with its own lifetime counter.
- Resolves player hits and misses, and maintains the running score, which is fed back as the generator's modulus.
- Its score output must therefore never be 0.

Parameters:
SPAWN_PERIOD, 25000000, clock cycles between spawn attempts (>=2)
LIFETIME, 50000000, cycles a target stays live before it counts as a miss (>=2)
NUM_TARGETS, 10, number of slots; the index width is 4
SCORE_INIT, 1, score value after reset and on game start (>=1)
HIT_POINTS, 1, score added per valid hit
MAX_MISSES, 5, misses that end the game

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
game_en  in  1  level; high = play
ran_num_ten  in  4  random slot index from the generator, sampled on spawn ticks
hit_valid  in  1  single-cycle strobe: player struck a slot
hit_idx  in  4  slot struck, qualified by hit_valid
target_active  out  10  bit i = slot i live
score  out  32  current score, always >= 1
spawn_pulse  out  1  one cycle when a target is placed
hit_ok  out  1  one cycle on a valid hit
hit_bad  out  1  one cycle on a hit to an empty or out-of-range slot
miss_pulse  out  1  one cycle when a target expires
game_over  out  1  level, high in state OVER

Behaviour:
- Reset values (async): target_active=0, score=SCORE_INIT, all pulses=0, game_over=0, miss count=0, spawn timer=0, state=IDLE.
- FSM states and transitions:
  - IDLE -> RUN when game_en=1. Entry into RUN loads score=SCORE_INIT, clears the miss count and the timer.
  - RUN -> IDLE when game_en=0. Clears target_active and holds score.
  - RUN -> OVER on the cycle the miss count reaches MAX_MISSES. Clears target_active.
  - OVER -> IDLE when game_en=0. game_over=1 only in OVER.
- Spawn timer (RUN only): counts 0..SPAWN_PERIOD-1 and wraps. At terminal count, ran_num_ten is sampled:
  - Index values 10-15 map to index-10.
  - If the slot is free, it is used. If occupied, the next free slot upward (wrapping 9->0) is used.
  - If all slots are live, the spawn is dropped and spawn_pulse stays 0.
  - On a successful spawn, target_active bit and spawn_pulse assert on the following edge (latency 1).
- Each slot's lifetime counter loads LIFETIME-1 on spawn and decrements each cycle while live. On reaching 0, the slot clears, miss_pulse=1 and miss count+1 (all registered, 1 cycle).
- More than one expiry in the same cycle: miss_pulse is a single pulse, and the miss count adds the number of expiries, saturating at MAX_MISSES.
- Hit handling (RUN only; hit_valid is ignored elsewhere):
  - hit_idx<NUM_TARGETS and slot live: clear slot, score += HIT_POINTS saturating at 2^32-1, hit_ok next cycle.
  - Otherwise: hit_bad next cycle.
- Simultaneous events:
  - Hit and expiry on the same slot: the hit wins, with no miss.
  - Hit and spawn on the same slot: occupancy is judged from registered state, so a hit on a previously empty slot is hit_bad and the spawn proceeds.
  - Spawn probing uses pre-update occupancy; a slot freed this cycle is not reusable until the next cycle.
- Reset mid-game: immediate return to IDLE with the reset values above.

Optional Feature:
- Macro: MISS_PENALTY_EN.
- Defined: each expiry also decrements score by 1, floored at SCORE_INIT. Multiple expiries in one cycle decrement once per expiry, with the floor still applied.
- Undefined: misses never alter score.

Decomposition:
- Package target_pkg holds:
  - constants for slot index width (4) and score width (32);
  - FSM state encoding IDLE/RUN/OVER;
  - the index-folding function (>=10 maps to -10).
- Sub-module target_slot, instantiated NUM_TARGETS times: one live bit plus its lifetime counter, with spawn/clear inputs and an expire output.
- The top level holds the FSM, spawn timer, free-slot probe, score and miss counter.

Test Plan (SPAWN_PERIOD=8, LIFETIME=20, MAX_MISSES=3):
- Reset, then game_en=1 and ran_num_ten=4 -> spawn_pulse at the 8th RUN cycle; target_active=10'b0000010000; score=1.
- Slot 4 live, hit_valid with hit_idx=4 -> next cycle hit_ok=1, bit 4 clear, score=2; then hit_idx=4 again -> hit_bad=1, score unchanged.
- Slot 9 live, next spawn with ran_num_ten=9 -> slot 0 set; all 10 live -> spawn dropped, spawn_pulse=0.
- Target not hit -> miss_pulse exactly 20 cycles after its spawn_pulse; third miss -> game_over=1, target_active=0; game_en=0 -> IDLE.
- Hit on slot 2 in the same cycle its counter reaches 0 -> hit_ok=1, miss_pulse=0, score+1.
- Reset asserted mid-RUN with 3 live targets -> outputs return to reset values asynchronously; with MISS_PENALTY_EN, expiry at score=1 leaves score=1.
